seq_dec_display: RTL and testbench



---
 rtl/seq_dec_display_pkg.sv | 10 +
 rtl/seq_dec_display_seven_seg.sv | 23 ++
 rtl/seq_dec_display.sv | 88 ++++++++
 tb/tb_seq_dec_display.sv | 136 +++++++++++++
 4 files changed

// File: rtl/seq_dec_display_pkg.sv
// seq_dec_display_pkg: shared state encoding, blank pattern and digit-count helper.
package seq_dec_display_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_e;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  function automatic int min_digits(input int w);
    logic [63:0] m;
    min_digits = 0;
    for (m = (64'd1 << w) - 64'd1; m != 64'd0; m = m / 64'd10) min_digits++;
  endfunction
endpackage

// File: rtl/seq_dec_display_seven_seg.sv
// seven_seg: BCD digit to active-low gfedcba segments; codes above 9 go dark.
module seven_seg
  import seq_dec_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);
  always_comb begin
    case (bcd_i)
      4'd0: seg_o = 7'h40;
      4'd1: seg_o = 7'h79;
      4'd2: seg_o = 7'h24;
      4'd3: seg_o = 7'h30;
      4'd4: seg_o = 7'h19;
      4'd5: seg_o = 7'h12;
      4'd6: seg_o = 7'h02;
      4'd7: seg_o = 7'h78;
      4'd8: seg_o = 7'h00;
      4'd9: seg_o = 7'h10;
      default: seg_o = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/seq_dec_display.sv
// seq_dec_display: iterative double-dabble binary-to-BCD converter driving
// active-low seven-segment digits with optional leading-zero blanking.
module seq_dec_display
  import seq_dec_display_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_DIGITS = 3,
  parameter int BLANK_LZ   = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [7*NUM_DIGITS-1:0] seg_out,
  output logic                    out_valid
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam int BW = 4 * NUM_DIGITS;
  if (DATA_W < 1 || DATA_W > 32) begin : g_bad_w
    $error("seq_dec_display: DATA_W must be 1..32");
  end
  if (NUM_DIGITS < min_digits(DATA_W)) begin : g_bad_nd
    $error("seq_dec_display: NUM_DIGITS too small for DATA_W");
  end
  state_e                  state_q;
  logic [DATA_W-1:0]       bin_q;
  logic [BW-1:0]           acc_q, acc_d;
  logic [CW-1:0]           cnt_q;
  logic [NUM_DIGITS-1:0]   blank;
  logic [7*NUM_DIGITS-1:0] seg_d;
  logic                    zero_above;
  assign in_ready = (state_q == IDLE);
  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      acc_d[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ? acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
  end
  // Scan from the top digit down; a digit is blank while everything above it is zero.
  always_comb begin
    zero_above = 1'b1;
    blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (acc_q[4*i +: 4] == 4'd0);
      blank[i] = (BLANK_LZ != 0) && (i != 0) && zero_above;
    end
  end
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    seven_seg u_seg (
      .bcd_i(blank[g] ? 4'hF : acc_q[4*g +: 4]),
      .seg_o(seg_d[7*g +: 7])
    );
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      bcd_out   <= '0;
      seg_out   <= {NUM_DIGITS{SEG_BLANK}};
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state_q)
        IDLE: if (in_valid) begin
          bin_q   <= data_in;
          acc_q   <= '0;
          cnt_q   <= '0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          {acc_q, bin_q} <= {acc_d, bin_q} << 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(DATA_W - 1)) state_q <= LOAD;
        end
        LOAD: begin
          bcd_out   <= acc_q;
          seg_out   <= seg_d;
          out_valid <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_dec_display.sv
// tb_seq_dec_display: directed vectors against hand-computed BCD/segment values.
module tb_seq_dec_display;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  data_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, out_valid, ready0, valid0;
  logic [11:0] bcd_out, bcd0;
  logic [20:0] seg_out, seg0;
  logic [15:0] d16 = '0;
  logic        v16 = 1'b0;
  logic        r16, ov16;
  logic [19:0] bcd16;
  logic [34:0] seg16;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  seq_dec_display #(.DATA_W(8), .NUM_DIGITS(3), .BLANK_LZ(1)) dut (
    .clk(clk), .reset_n(rst_n), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
    .bcd_out(bcd_out), .seg_out(seg_out), .out_valid(out_valid));
  seq_dec_display #(.DATA_W(8), .NUM_DIGITS(3), .BLANK_LZ(0)) dut0 (
    .clk(clk), .reset_n(rst_n), .data_in(data_in), .in_valid(in_valid), .in_ready(ready0),
    .bcd_out(bcd0), .seg_out(seg0), .out_valid(valid0));
  seq_dec_display #(.DATA_W(16), .NUM_DIGITS(5), .BLANK_LZ(1)) dut16 (
    .clk(clk), .reset_n(rst_n), .data_in(d16), .in_valid(v16), .in_ready(r16),
    .bcd_out(bcd16), .seg_out(seg16), .out_valid(ov16));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send8(input logic [7:0] v);
    int n = 0;
    while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
    check("ready_before_send", in_ready, 1);
    @(negedge clk); data_in = v; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    check("latency8", n, 9);
    check("valid_lz0", valid0, 1);
  endtask

  initial begin
    int n, pulses;
    repeat (3) @(posedge clk);
    #1;
    check("rst_seg", seg_out, 21'h1FFFFF);
    check("rst_bcd", bcd_out, 0);
    check("rst_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_seg16", seg16, 35'h7FFFFFFFF);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("idle_valid", out_valid, 0);

    send8(8'd255);
    check("bcd_255", bcd_out, 12'h255);
    check("seg_255", seg_out, {7'h24, 7'h12, 7'h12});
    @(posedge clk); #1 check("pulse_one_cycle", out_valid, 0);
    check("hold_bcd", bcd_out, 12'h255);

    send8(8'd7);
    check("bcd_7", bcd_out, 12'h007);
    check("seg_7_lz", seg_out, {7'h7F, 7'h7F, 7'h78});
    check("seg_7_nolz", seg0, {7'h40, 7'h40, 7'h78});

    send8(8'd0);
    check("bcd_0", bcd_out, 12'h000);
    check("seg_0_lz", seg_out, {7'h7F, 7'h7F, 7'h40});
    check("seg_0_nolz", seg0, {7'h40, 7'h40, 7'h40});

    send8(8'd40);
    check("bcd_40", bcd0, 12'h040);
    check("seg_40_nolz", seg0, {7'h40, 7'h19, 7'h40});
    check("seg_40_lz", seg_out, {7'h7F, 7'h19, 7'h40});

    @(negedge clk); data_in = 8'd100; in_valid = 1'b1;
    @(posedge clk); #1 data_in = 8'd99;
    check("busy_ready", in_ready, 0);
    pulses = 0;
    for (int t = 1; t <= 25; t++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
      if (t == 9) begin
        check("hs_valid1", out_valid, 1);
        check("hs_ready_with_valid", in_ready, 1);
        check("hs_bcd100", bcd_out, 12'h100);
        check("hs_seg100", seg_out, {7'h79, 7'h40, 7'h40});
      end
      if (t == 10) begin
        check("hs_second_accept", in_ready, 0);
        in_valid = 1'b0;
      end
      if (t == 19) begin
        check("hs_valid2", out_valid, 1);
        check("hs_bcd99", bcd_out, 12'h099);
        check("hs_seg99", seg_out, {7'h7F, 7'h10, 7'h10});
      end
    end
    check("hs_pulses", pulses, 2);

    @(negedge clk); data_in = 8'd50; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_seg", seg_out, 21'h1FFFFF);
    check("midrst_bcd", bcd_out, 0);
    check("midrst_ready", in_ready, 1);
    check("midrst_valid", out_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    pulses = 0;
    for (int t = 0; t < 12; t++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check("midrst_no_pulse", pulses, 0);

    @(negedge clk); d16 = 16'hFFFF; v16 = 1'b1;
    @(posedge clk); #1 v16 = 1'b0;
    n = 0;
    while (!ov16 && n < 60) begin @(posedge clk); #1; n++; end
    check("latency16", n, 17);
    check("bcd_65535", bcd16, 20'h65535);
    check("seg_65535", seg16, {7'h02, 7'h12, 7'h12, 7'h30, 7'h12});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
